id_ex_stage: RTL

//  ID/EX pipeline register with load-use hazard detection, placed directly after the control decoder.
//  - Latches decoder control bits, register operands, immediate and register indices into EX each cycle.
//  - Detects load-use hazards against the instruction currently in EX.
//  - Drives NoOp back to the decoder and stalls PC and IF/ID.
//  - Holds EX contents under a memory stall and counts inserted bubbles.

---
 rtl/id_ex_stage_pkg.sv | 35 +++
 rtl/id_ex_stage_load_use_detect.sv | 18 +
 rtl/id_ex_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX stage: ALU operation classes,
// the packed EX control bundle and its bubble value.
package id_ex_stage_pkg;

  localparam int ALUOP_LEN      = 3;
  localparam int OP_LEN         = 7;
  localparam int REG_AW_DEFAULT = 5;

  typedef enum logic [ALUOP_LEN-1:0] {
    ALUOP_NO = 3'd0,
    ALUOP_R  = 3'd1,
    ALUOP_I  = 3'd2,
    ALUOP_LS = 3'd3,
    ALUOP_BR = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    memto_reg;
    logic    mem_read;
    logic    mem_write;
    alu_op_e alu_op;
    logic    alu_src;
  } ex_ctrl_t;

  localparam ex_ctrl_t CTRL_BUBBLE = '{
    reg_write: 1'b0,
    memto_reg: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    alu_op:    ALUOP_NO,
    alu_src:   1'b0
  };

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard check: the load in EX writes a register that the
// instruction in ID reads. Writes to x0 are never a dependency.
module load_use_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  output logic              hazard_o
);

  assign hazard_o = ex_mem_read_i && (ex_rd_i != '0) &&
                    ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoder outputs into EX, inserts one
// bubble per load-use hazard, freezes under a memory stall, counts bubbles.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 MemStall_i,
  input  logic                 RegWrite_i,
  input  logic                 MemtoReg_i,
  input  logic                 MemRead_i,
  input  logic                 MemWrite_i,
  input  logic [ALUOP_LEN-1:0] ALUOp_i,
  input  logic                 ALUSrc_i,
  input  logic [REG_AW-1:0]    RS1_i,
  input  logic [REG_AW-1:0]    RS2_i,
  input  logic [REG_AW-1:0]    RD_i,
  input  logic [DATA_W-1:0]    RS1Data_i,
  input  logic [DATA_W-1:0]    RS2Data_i,
  input  logic [DATA_W-1:0]    Imm_i,
  input  logic [9:0]           Funct_i,
  output logic                 NoOp_o,
  output logic                 PCWrite_o,
  output logic                 IFIDStall_o,
  output logic                 EX_RegWrite_o,
  output logic                 EX_MemtoReg_o,
  output logic                 EX_MemRead_o,
  output logic                 EX_MemWrite_o,
  output logic [ALUOP_LEN-1:0] EX_ALUOp_o,
  output logic                 EX_ALUSrc_o,
  output logic [REG_AW-1:0]    EX_RS1_o,
  output logic [REG_AW-1:0]    EX_RS2_o,
  output logic [REG_AW-1:0]    EX_RD_o,
  output logic [DATA_W-1:0]    EX_RS1Data_o,
  output logic [DATA_W-1:0]    EX_RS2Data_o,
  output logic [DATA_W-1:0]    EX_Imm_o,
  output logic [9:0]           EX_Funct_o,
  output logic                 EX_Valid_o,
  output logic [CNT_W-1:0]     BubbleCnt_o
);

  ex_ctrl_t          ctrl_d, ctrl_q;
  logic [REG_AW-1:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic [DATA_W-1:0] rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q;
  logic [DATA_W-1:0] imm_d, imm_q;
  logic [9:0]        funct_d, funct_q;
  logic              valid_d, valid_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              hazard;

  load_use_detect #(.REG_AW(REG_AW)) u_detect (
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rd_i       (rd_q),
    .id_rs1_i      (RS1_i),
    .id_rs2_i      (RS2_i),
    .hazard_o      (hazard)
  );

  assign NoOp_o      = hazard;
  assign IFIDStall_o = hazard | MemStall_i;
  assign PCWrite_o   = ~(hazard | MemStall_i);

  always_comb begin
    // NOTE: every next-state signal defaults to its held value first, so
    // no path through the branches below can leave one unassigned (latch).
    ctrl_d     = ctrl_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    funct_d    = funct_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;

    if (!MemStall_i) begin
      if (hazard) begin
        // Bubble is built here rather than trusting the decoder's NoOp path.
        ctrl_d     = CTRL_BUBBLE;
        rs1_d      = '0;
        rs2_d      = '0;
        rd_d       = '0;
        rs1_data_d = '0;
        rs2_data_d = '0;
        imm_d      = '0;
        funct_d    = '0;
        valid_d    = 1'b0;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end else begin
        ctrl_d = '{
          reg_write: RegWrite_i,
          memto_reg: MemtoReg_i,
          mem_read:  MemRead_i,
          mem_write: MemWrite_i,
          alu_op:    alu_op_e'(ALUOp_i),
          alu_src:   ALUSrc_i
        };
        rs1_d      = RS1_i;
        rs2_d      = RS2_i;
        rd_d       = RD_i;
        rs1_data_d = RS1Data_i;
        rs2_data_d = RS2Data_i;
        imm_d      = Imm_i;
        funct_d    = Funct_i;
        valid_d    = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q     <= CTRL_BUBBLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      funct_q    <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      funct_q    <= funct_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign EX_RegWrite_o = ctrl_q.reg_write;
  assign EX_MemtoReg_o = ctrl_q.memto_reg;
  assign EX_MemRead_o  = ctrl_q.mem_read;
  assign EX_MemWrite_o = ctrl_q.mem_write;
  assign EX_ALUOp_o    = ctrl_q.alu_op;
  assign EX_ALUSrc_o   = ctrl_q.alu_src;
  assign EX_RS1_o      = rs1_q;
  assign EX_RS2_o      = rs2_q;
  assign EX_RD_o       = rd_q;
  assign EX_RS1Data_o  = rs1_data_q;
  assign EX_RS2Data_o  = rs2_data_q;
  assign EX_Imm_o      = imm_q;
  assign EX_Funct_o    = funct_q;
  assign EX_Valid_o    = valid_q;
  assign BubbleCnt_o   = cnt_q;

endmodule
